// File: rtl/fir_mac_core_if.sv
// fir_mac_core_if -- bus bundle for the FIR multiply-accumulate core.
//
// Groups three groups of signals:
//   upstream FIFO read port : iEN, iEMPT, iRDAT (in), oRINC (out)
//   coefficient write port  : iCWE, iCADDR, iCDAT (in), oCBSY (out)
//   result port             : oDAT, oVLD (out)
//
// Handshake rules:
//   FIFO read: oRINC is a one-cycle pop pulse. iRDAT must hold the popped
//   word in the cycle after oRINC (read latency 1). iEMPT only matters while
//   the core is idle.
//   Coefficient write: the write happens on the rising edge where iCWE=1 and
//   oCBSY=0. A write while oCBSY=1 is dropped without any retry.
//   Result: oVLD is a one-cycle strobe. oDAT keeps its value until the next
//   strobe.
//
// Modports: master = the environment (FIFO, coefficient loader, sink);
//           slave  = the core.
interface fir_mac_core_if #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int TAPS = 8,
  parameter int OW   = DW + CW + $clog2(TAPS)
);
  logic                     iEN;
  logic                     iEMPT;
  logic [DW-1:0]            iRDAT;
  logic                     oRINC;
  logic                     iCWE;
  logic [$clog2(TAPS)-1:0]  iCADDR;
  logic [CW-1:0]            iCDAT;
  logic                     oCBSY;
  logic [OW-1:0]            oDAT;
  logic                     oVLD;

  modport master (
    output iEN, iEMPT, iRDAT, iCWE, iCADDR, iCDAT,
    input  oRINC, oCBSY, oDAT, oVLD
  );

  modport slave (
    input  iEN, iEMPT, iRDAT, iCWE, iCADDR, iCDAT,
    output oRINC, oCBSY, oDAT, oVLD
  );
endinterface

// File: rtl/fir_mac_core.sv
// fir_mac_core -- serial TAPS-tap FIR filter that uses one multiplier.
//
// For each sample, the core fetches one word from an upstream FIFO and
// shifts it into the delay line. It then accumulates x[k]*h[k] over TAPS
// cycles and presents y[n] on oDAT with a one-cycle oVLD strobe. The
// arithmetic is exact: OW = DW+CW+log2(TAPS), so the sum cannot overflow.
//
// Ports:
//   iCLK    rising-edge clock
//   iRSTN   asynchronous active-low reset; clears all state including
//           the coefficients
//   bus     fir_mac_core_if.slave (FIFO read, coefficient write, result)
//   oState  current FSM state (0 IDLE, 1 READ, 2 LOAD, 3 MAC), for debug
module fir_mac_core #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int TAPS = 8,
  parameter int OW   = DW + CW + $clog2(TAPS)
) (
  input  logic        iCLK,
  input  logic        iRSTN,
  fir_mac_core_if.slave bus,
  output logic [1:0]  oState
);

  localparam int KW = $clog2(TAPS);
  localparam int PW = DW + CW;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, LOAD = 2'd2, MAC = 2'd3} state_t;

  state_t state, nextState;

  logic signed [DW-1:0] x [TAPS];
  logic signed [CW-1:0] h [TAPS];
  logic signed [OW-1:0] acc;
  logic signed [OW-1:0] dat;
  logic                 vld;
  logic [KW-1:0]        k;

  logic                 fetch;
  logic                 lastTap;
  logic signed [PW-1:0] xe, he, prod;
  logic signed [OW-1:0] prodExt;

  assign fetch   = bus.iEN && !bus.iEMPT;
  assign lastTap = (k == KW'(TAPS - 1));

  // State register
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic. A fetch from a quiet IDLE goes through READ, which
  // issues the pop. In the oVLD cycle, IDLE issues the pop itself and goes
  // straight to LOAD. This keeps back-to-back samples at TAPS+2 cycles
  // apart.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (fetch) nextState = vld ? LOAD : READ;
      READ: nextState = LOAD;
      LOAD: nextState = MAC;
      MAC:  if (lastTap) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.oRINC = (state == READ) || (state == IDLE && fetch && vld);
    bus.oCBSY = (state != IDLE);
    bus.oVLD  = vld;
    bus.oDAT  = dat;
    oState    = state;
  end

  // Form the full-width signed product, then sign-extend it to the
  // accumulator width.
  always_comb begin
    xe      = {{CW{x[k][DW-1]}}, x[k]};
    he      = {{DW{h[k][CW-1]}}, h[k]};
    prod    = xe * he;
    prodExt = {{(OW-PW){prod[PW-1]}}, prod};
  end

  // Datapath: coefficient bank, delay line, accumulator, result register.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
      acc <= '0;
      dat <= '0;
      vld <= 1'b0;
      k   <= '0;
    end else begin
      vld <= 1'b0;
      if (state == IDLE && bus.iCWE) h[bus.iCADDR] <= bus.iCDAT;
      case (state)
        LOAD: begin
          x[0] <= bus.iRDAT;
          for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
          acc <= '0;
          k   <= '0;
        end
        MAC: begin
          acc <= acc + prodExt;
          k   <= k + KW'(1);
          if (lastTap) begin
            dat <= acc + prodExt;
            vld <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_core.sv
// tb_fir_mac_core -- directed and random checks for fir_mac_core.
// An upstream FIFO model feeds samples from src_q. Every pop pushes the
// reference FIR output into exp_q, and exp_q is compared against oDAT when
// oVLD strobes.
module tb_fir_mac_core;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int TAPS = 8;
  localparam int OW   = 19;

  logic       iCLK;
  logic       iRSTN;
  logic [1:0] dbgState;

  fir_mac_core_if #(.DW(DW), .CW(CW), .TAPS(TAPS)) bus ();

  fir_mac_core #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
    .iCLK   (iCLK),
    .iRSTN  (iRSTN),
    .bus    (bus),
    .oState (dbgState)
  );

  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            rinc_cnt = 0;
  int            vld_cnt  = 0;
  int            prev_rinc = -1;
  bit            check_period = 1'b0;
  int            src_q[$];
  logic [OW-1:0] exp_q[$];
  int            rinc_q[$];
  int            x_m[TAPS];
  int            h_m[TAPS];
  logic [OW-1:0] last_exp = '0;

  // Clock and reset
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  always @(posedge iCLK) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < TAPS; i++) begin
      x_m[i] = 0;
      h_m[i] = 0;
    end
  endtask

  // Upstream FIFO, reference model and scoreboard.
  always @(negedge iCLK) begin
    int s;
    int sum;
    bus.iEMPT = (src_q.size() == 0);
    #1;
    if (bus.oVLD === 1'b1) begin
      vld_cnt++;
      check("exp_q_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        last_exp = exp_q.pop_front();
        check("odat", 32'(bus.oDAT), 32'(last_exp));
      end
      check("rinc_before_vld", 32'(rinc_q.size() > 0), 1);
      if (rinc_q.size() > 0) check("latency", cyc - rinc_q.pop_front(), TAPS + 2);
    end
    if (bus.oRINC === 1'b1) begin
      rinc_cnt++;
      if (check_period && prev_rinc >= 0) check("rinc_period", cyc - prev_rinc, TAPS + 2);
      prev_rinc = cyc;
      rinc_q.push_back(cyc);
      check("rinc_src_avail", 32'(src_q.size() > 0), 1);
      if (src_q.size() > 0) begin
        s = src_q.pop_front();
        bus.iRDAT = DW'(s);
        for (int i = TAPS - 1; i > 0; i--) x_m[i] = x_m[i-1];
        x_m[0] = s;
        sum = 0;
        for (int i = 0; i < TAPS; i++) sum += x_m[i] * h_m[i];
        exp_q.push_back(OW'(sum));
      end
    end
  end

  // Driver tasks
  task automatic write_coef(input int a, input int d, input bit apply);
    @(negedge iCLK);
    bus.iCWE   = 1'b1;
    bus.iCADDR = 3'(a);
    bus.iCDAT  = CW'(d);
    if (apply) h_m[a] = d;
    @(negedge iCLK);
    bus.iCWE = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge iCLK);
      #2;
      if (src_q.size() == 0 && exp_q.size() == 0 && dbgState == 2'd0) done = 1'b1;
    end
    check("idle_reached", 32'(done), 1);
  endtask

  task automatic wait_rinc(input int budget);
    int c0 = rinc_cnt;
    for (int i = 0; i < budget && rinc_cnt == c0; i++) begin
      @(negedge iCLK);
      #2;
    end
    check("rinc_seen", 32'(rinc_cnt != c0), 1);
  endtask

  task automatic impulse_after_flush();
    for (int i = 0; i < TAPS; i++) src_q.push_back(0);
    src_q.push_back(1);
    wait_idle(300);
  endtask

  initial begin
    int v0;
    int r0;
    logic signed [7:0] t;
    iRSTN      = 1'b0;
    bus.iEN    = 1'b0;
    bus.iRDAT  = '0;
    bus.iCWE   = 1'b0;
    bus.iCADDR = '0;
    bus.iCDAT  = '0;
    clear_model();

    // Reset state
    repeat (3) @(negedge iCLK);
    #2;
    check("rst_orinc", 32'(bus.oRINC), 0);
    check("rst_ovld",  32'(bus.oVLD), 0);
    check("rst_odat",  32'(bus.oDAT), 0);
    check("rst_ocbsy", 32'(bus.oCBSY), 0);
    check("rst_state", 32'(dbgState), 0);
    @(negedge iCLK);
    iRSTN   = 1'b1;
    bus.iEN = 1'b1;

    // Impulse response with h = 1..8, streamed back to back
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1, 1'b1);
    prev_rinc    = -1;
    check_period = 1'b1;
    src_q.push_back(1);
    for (int i = 0; i < TAPS; i++) src_q.push_back(0);
    wait_idle(300);
    check_period = 1'b0;
    check("impulse_tail", 32'(bus.oDAT), 0);

    // Full-scale negative
    for (int i = 0; i < TAPS; i++) write_coef(i, -128, 1'b1);
    for (int i = 0; i < TAPS; i++) src_q.push_back(-128);
    wait_idle(300);
    check("fullscale_last", 32'(bus.oDAT), 131072);

    // Random coefficients and samples
    for (int i = 0; i < TAPS; i++) begin
      t = 8'($urandom_range(0, 255));
      write_coef(i, int'(t), 1'b1);
    end
    for (int i = 0; i < 12; i++) begin
      t = 8'($urandom_range(0, 255));
      src_q.push_back(int'(t));
    end
    wait_idle(400);

    // Stall with iEN=0, then with an empty FIFO
    @(negedge iCLK);
    bus.iEN = 1'b0;
    src_q.push_back(7);
    src_q.push_back(-3);
    r0 = rinc_cnt;
    v0 = vld_cnt;
    repeat (30) @(negedge iCLK);
    #2;
    check("stall_en_rinc", rinc_cnt, r0);
    check("stall_en_vld", vld_cnt, v0);
    check("stall_en_odat", 32'(bus.oDAT), 32'(last_exp));
    bus.iEN = 1'b1;
    wait_idle(200);
    r0 = rinc_cnt;
    v0 = vld_cnt;
    repeat (20) @(negedge iCLK);
    #2;
    check("stall_empty_rinc", rinc_cnt, r0);
    check("stall_empty_vld", vld_cnt, v0);
    check("stall_empty_odat", 32'(bus.oDAT), 32'(last_exp));

    // Busy write is dropped; an idle write takes effect
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1, 1'b1);
    src_q.push_back(0);
    wait_rinc(50);
    write_coef(0, 5, 1'b0);
    wait_idle(200);
    impulse_after_flush();
    check("busy_h0_kept", 32'(bus.oDAT), 1);
    write_coef(0, 5, 1'b1);
    impulse_after_flush();
    check("idle_h0_written", 32'(bus.oDAT), 5);

    // Reset in the middle of MAC
    src_q.push_back(1);
    wait_rinc(50);
    repeat (5) @(posedge iCLK);
    #2;
    iRSTN = 1'b0;
    #1;
    check("mid_rst_orinc", 32'(bus.oRINC), 0);
    check("mid_rst_ovld",  32'(bus.oVLD), 0);
    check("mid_rst_odat",  32'(bus.oDAT), 0);
    check("mid_rst_ocbsy", 32'(bus.oCBSY), 0);
    src_q.delete();
    exp_q.delete();
    rinc_q.delete();
    clear_model();
    repeat (2) @(negedge iCLK);
    iRSTN = 1'b1;
    v0 = vld_cnt;
    repeat (20) @(negedge iCLK);
    #2;
    check("mid_rst_no_vld", vld_cnt, v0);
    src_q.push_back(1);
    wait_idle(100);
    check("post_rst_impulse", 32'(bus.oDAT), 0);
    check("post_rst_vld_cnt", vld_cnt, v0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
